// File: rtl/draw_start_rom.sv
// Start-screen banner overlay: turns VGA timing into image ROM addresses and keys the
// returned RGB444 pixels over the pass-through video, blinking on a frame count.
module draw_start_rom #(
   parameter int unsigned XPOS         = 200,
   parameter int unsigned YPOS         = 276,
   parameter int unsigned IMG_W        = 400,
   parameter int unsigned IMG_H        = 48,
   parameter int unsigned BLINK_FRAMES = 30,
   parameter logic [11:0] KEY_COLOR    = 12'h000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [10:0] hcount_in,
   input  logic [10:0] vcount_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        hblnk_in,
   input  logic        vblnk_in,
   input  logic [11:0] rgb_in,
   output logic [14:0] rom_addr,
   input  logic [11:0] rom_pixel,
   output logic [10:0] hcount_out,
   output logic [10:0] vcount_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        hblnk_out,
   output logic        vblnk_out,
   output logic [11:0] rgb_out
);

   localparam int unsigned CW         = 11;
   localparam int unsigned AW         = 15;
   localparam int unsigned X_LAST     = XPOS + IMG_W - 1;
   localparam int unsigned Y_LAST     = YPOS + IMG_H - 1;
   localparam int unsigned BLINK_LAST = (BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0;
   localparam int unsigned CNT_W      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic            w_in_box;
   logic [CW-1:0]   w_dx;
   logic [CW-1:0]   w_dy;
   logic [AW-1:0]   w_addr;
   logic            w_tick;
   logic            w_show;

   logic [CW-1:0]   r_hc1, r_vc1, r_hc2, r_vc2;
   logic            r_hs1, r_vs1, r_hb1, r_vb1, r_box1, r_en1;
   logic            r_hs2, r_vs2, r_hb2, r_vb2, r_box2, r_en2;
   logic [11:0]     r_rgb1, r_rgb2;
   logic            r_vb_d;
   logic            r_visible;
   logic [CNT_W-1:0] r_cnt;

   // Address generation for the current input pixel
   always_comb begin
      w_in_box = (hcount_in >= CW'(XPOS)) && (hcount_in <= CW'(X_LAST)) &&
                 (vcount_in >= CW'(YPOS)) && (vcount_in <= CW'(Y_LAST)) &&
                 !hblnk_in && !vblnk_in;
      w_dx     = hcount_in - CW'(XPOS);
      w_dy     = vcount_in - CW'(YPOS);
      w_addr   = '0;
      if (w_in_box) begin
         w_addr = AW'(w_dy) * AW'(IMG_W) + AW'(w_dx);
      end
   end

   assign w_tick = vblnk_in & ~r_vb_d;
   assign w_show = r_box2 & r_en2 & r_visible & (rom_pixel != KEY_COLOR);

   // Three-stage video pipeline; S2 lines up with the ROM read latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr   <= '0;
         r_hc1      <= '0;
         r_vc1      <= '0;
         r_hs1      <= 1'b0;
         r_vs1      <= 1'b0;
         r_hb1      <= 1'b0;
         r_vb1      <= 1'b0;
         r_box1     <= 1'b0;
         r_en1      <= 1'b0;
         r_rgb1     <= '0;
         r_hc2      <= '0;
         r_vc2      <= '0;
         r_hs2      <= 1'b0;
         r_vs2      <= 1'b0;
         r_hb2      <= 1'b0;
         r_vb2      <= 1'b0;
         r_box2     <= 1'b0;
         r_en2      <= 1'b0;
         r_rgb2     <= '0;
         hcount_out <= '0;
         vcount_out <= '0;
         hsync_out  <= 1'b0;
         vsync_out  <= 1'b0;
         hblnk_out  <= 1'b0;
         vblnk_out  <= 1'b0;
         rgb_out    <= '0;
      end else begin
         rom_addr   <= w_addr;
         r_hc1      <= hcount_in;
         r_vc1      <= vcount_in;
         r_hs1      <= hsync_in;
         r_vs1      <= vsync_in;
         r_hb1      <= hblnk_in;
         r_vb1      <= vblnk_in;
         r_box1     <= w_in_box;
         r_en1      <= enable;
         r_rgb1     <= rgb_in;
         r_hc2      <= r_hc1;
         r_vc2      <= r_vc1;
         r_hs2      <= r_hs1;
         r_vs2      <= r_vs1;
         r_hb2      <= r_hb1;
         r_vb2      <= r_vb1;
         r_box2     <= r_box1;
         r_en2      <= r_en1;
         r_rgb2     <= r_rgb1;
         hcount_out <= r_hc2;
         vcount_out <= r_vc2;
         hsync_out  <= r_hs2;
         vsync_out  <= r_vs2;
         hblnk_out  <= r_hb2;
         vblnk_out  <= r_vb2;
         rgb_out    <= w_show ? rom_pixel : r_rgb2;
      end
   end

   // Blink phase counter; a low enable overrides a coincident frame tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vb_d    <= 1'b0;
         r_cnt     <= '0;
         r_visible <= 1'b1;
      end else begin
         r_vb_d <= vblnk_in;
         if (!enable || (BLINK_FRAMES == 0)) begin
            r_cnt     <= '0;
            r_visible <= 1'b1;
         end else if (w_tick) begin
            if (r_cnt == CNT_W'(BLINK_LAST)) begin
               r_cnt     <= '0;
               r_visible <= ~r_visible;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_draw_start_rom.sv
// Bench for draw_start_rom: random and directed VGA streams scored against a
// pixel-level reference model and a behavioural image ROM.
module tb_draw_start_rom;

   localparam int XPOS  = 200;
   localparam int YPOS  = 276;
   localparam int IMG_W = 400;
   localparam int IMG_H = 48;
   localparam int BLINK = 2;

   typedef struct {
      int          h;
      int          v;
      bit          hs;
      bit          vs;
      bit          hb;
      bit          vb;
      logic [11:0] rgb;
      bit          en;
   } px_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [10:0] hcount_in = '0;
   logic [10:0] vcount_in = '0;
   logic        hsync_in = 1'b0;
   logic        vsync_in = 1'b0;
   logic        hblnk_in = 1'b0;
   logic        vblnk_in = 1'b0;
   logic [11:0] rgb_in = '0;
   logic [14:0] rom_addr;
   logic [11:0] rom_pixel = '0;
   logic [10:0] hcount_out;
   logic [10:0] vcount_out;
   logic        hsync_out;
   logic        vsync_out;
   logic        hblnk_out;
   logic        vblnk_out;
   logic [11:0] rgb_out;

   int  n_tests = 0;
   int  n_fail  = 0;
   int  m_ticks = 0;
   bit  m_prev_vb = 1'b0;
   px_t h1, h2, zp;
   bit  en_state;

   draw_start_rom #(.BLINK_FRAMES(BLINK)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .hcount_in(hcount_in), .vcount_in(vcount_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in),
      .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
      .rgb_in(rgb_in), .rom_addr(rom_addr), .rom_pixel(rom_pixel),
      .hcount_out(hcount_out), .vcount_out(vcount_out),
      .hsync_out(hsync_out), .vsync_out(vsync_out),
      .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
      .rgb_out(rgb_out)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] rom_fn(input int a);
      if (a % 5 == 3) return 12'h000;
      return 12'((a * 37 + 11) ^ (a >> 3));
   endfunction

   always_ff @(posedge clk) rom_pixel <= rom_fn(int'(rom_addr));

   function automatic bit in_box(input px_t p);
      return p.h >= XPOS && p.h < XPOS + IMG_W && p.v >= YPOS && p.v < YPOS + IMG_H &&
             !p.hb && !p.vb;
   endfunction

   function automatic int addr_of(input px_t p);
      return in_box(p) ? (p.v - YPOS) * IMG_W + (p.h - XPOS) : 0;
   endfunction

   function automatic bit vis_of(input int n);
      return ((n / BLINK) % 2) == 0;
   endfunction

   function automatic px_t mk(input int h, input int v, input bit hs, input bit vs,
                              input bit hb, input bit vb, input logic [11:0] rgb,
                              input bit en);
      px_t p;
      p.h = h; p.v = v; p.hs = hs; p.vs = vs; p.hb = hb; p.vb = vb; p.rgb = rgb; p.en = en;
      return p;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One pixel clock: drive x, then score the outputs of the pixel two edges earlier
   task automatic drive(input px_t x);
      px_t         e;
      int          a;
      logic [11:0] rgb_exp;
      hcount_in = 11'(x.h);
      vcount_in = 11'(x.v);
      hsync_in  = x.hs;
      vsync_in  = x.vs;
      hblnk_in  = x.hb;
      vblnk_in  = x.vb;
      rgb_in    = x.rgb;
      enable    = x.en;
      @(posedge clk);
      #1;
      e = h2;
      a = addr_of(e);
      rgb_exp = (in_box(e) && e.en && vis_of(m_ticks) && rom_fn(a) != 12'h000) ?
                rom_fn(a) : e.rgb;
      check("hcount_out", 32'(hcount_out), 32'(e.h));
      check("vcount_out", 32'(vcount_out), 32'(e.v));
      check("hsync_out",  32'(hsync_out),  32'(e.hs));
      check("vsync_out",  32'(vsync_out),  32'(e.vs));
      check("hblnk_out",  32'(hblnk_out),  32'(e.hb));
      check("vblnk_out",  32'(vblnk_out),  32'(e.vb));
      check("rgb_out",    32'(rgb_out),    32'(rgb_exp));
      check("rom_addr",   32'(rom_addr),   32'(addr_of(x)));
      if (!x.en) m_ticks = 0;
      else if (x.vb && !m_prev_vb) m_ticks++;
      m_prev_vb = x.vb;
      h2 = h1;
      h1 = x;
   endtask

   task automatic idle(input bit en);
      drive(mk(1000, 280, 1'b0, 1'b0, 1'b1, 1'b0, 12'($urandom), en));
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      check("rst_rom_addr", 32'(rom_addr), 32'd0);
      check("rst_hcount",   32'(hcount_out), 32'd0);
      check("rst_vcount",   32'(vcount_out), 32'd0);
      check("rst_sync",     32'({hsync_out, vsync_out}), 32'd0);
      check("rst_blank",    32'({hblnk_out, vblnk_out}), 32'd0);
      check("rst_rgb",      32'(rgb_out), 32'd0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      h1 = zp; h2 = zp;
      m_ticks = 0;
      m_prev_vb = 1'b0;
   endtask

   // Probe a fixed banner pixel, then end the frame with a vblank pulse
   task automatic blink_frame(input bit exp_vis, input bit en_at_tick);
      drive(mk(300, 280, 1'b0, 1'b0, 1'b0, 1'b0, 12'h5AF, 1'b1));
      idle(1'b1);
      idle(1'b1);
      check("blink_probe", 32'(rgb_out), exp_vis ? 32'(rom_fn(1700)) : 32'h5AF);
      drive(mk(0, 600, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, en_at_tick));
      for (int i = 0; i < 3; i++) drive(mk(0, 601, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1));
      idle(1'b1);
   endtask

   task automatic vga_line(input int v);
      for (int h = 0; h < 1056; h++) begin
         drive(mk(h, v, (h >= 840 && h < 968), (v >= 601 && v < 605),
                  (h >= 800), (v >= 600), 12'($urandom), 1'b1));
      end
   endtask

   initial begin
      zp = mk(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
      h1 = zp; h2 = zp;
      #3;
      check("init_rom_addr", 32'(rom_addr), 32'd0);
      check("init_rgb",      32'(rgb_out), 32'd0);
      check("init_hcount",   32'(hcount_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Line sweep through the top row of the banner
      for (int h = 195; h <= 605; h++) begin
         drive(mk(h, 276, 1'b0, 1'b0, 1'b0, 1'b0, 12'($urandom), 1'b1));
         if (h == 200) check("addr_first", 32'(rom_addr), 32'd0);
         if (h == 599) check("addr_row_end", 32'(rom_addr), 32'd399);
         if (h == 600) check("addr_past_box", 32'(rom_addr), 32'd0);
      end

      drive(mk(205, 277, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 1'b1));
      check("addr_405", 32'(rom_addr), 32'd405);
      drive(mk(599, 323, 1'b0, 1'b0, 1'b0, 1'b0, 12'h321, 1'b1));
      check("addr_last", 32'(rom_addr), 32'd19199);
      drive(mk(203, 276, 1'b0, 1'b0, 1'b0, 1'b0, 12'h5AF, 1'b1));
      idle(1'b1);
      idle(1'b1);
      check("key_color", 32'(rgb_out), 32'h5AF);

      // Randomised pixels around the box, with a reset dropped mid-stream
      en_state = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(63, 0) == 0) en_state = ~en_state;
         drive(mk($urandom_range(610, 190), $urandom_range(330, 270),
                  1'($urandom), 1'($urandom),
                  ($urandom_range(15, 0) == 0), ($urandom_range(31, 0) == 0),
                  12'($urandom), en_state));
         if (i == 1500) do_reset();
      end

      // Blink sequence, enable drop while hidden, and tick coinciding with enable low
      idle(1'b0);
      for (int f = 0; f < 7; f++) blink_frame((f % 4) < 2, 1'b1);
      for (int i = 0; i < 3; i++) idle(1'b0);
      blink_frame(1'b1, 1'b1);
      blink_frame(1'b1, 1'b1);
      blink_frame(1'b0, 1'b0);
      blink_frame(1'b1, 1'b1);
      blink_frame(1'b1, 1'b1);
      blink_frame(1'b0, 1'b1);

      // Real 800x600 timing lines across the banner and the vertical blank
      for (int v = 274; v <= 279; v++) vga_line(v);
      for (int v = 598; v <= 606; v++) vga_line(v);
      vga_line(626);
      vga_line(627);
      vga_line(0);
      vga_line(1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
